// File: rtl/cordic_job_arbiter.sv
// Round-robin front end that shares one iterative CORDIC core between two requesters.
// One job in flight: IDLE -> START -> WAIT -> RESP -> IDLE, with a bounded wait for core_done.
module cordic_job_arbiter #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_angle,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_angle,
  output logic              core_start,
  output logic [DATA_W-1:0] core_angle,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_cos,
  input  logic [DATA_W-1:0] core_sin,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_cos,
  output logic [DATA_W-1:0] rsp_sin,
  output logic              rsp_err,
  output logic              busy,
  output logic [1:0]        fsm_state
);

  // Handshakes: a job transfers on the rising edge where reqN_valid && reqN_ready,
  // a response transfers where rsp_valid && rsp_ready; a valid, once raised, is held
  // with its payload until that transfer.

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  // cnt holds the WAIT cycles already spent, so the WAIT cycle with cnt == TIMEOUT-2
  // is the (TIMEOUT-1)th after core_start and the error response lands TIMEOUT
  // cycles after core_start, exactly where a done in that last cycle would land.
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(TIMEOUT - 2);

  logic [1:0]       state;
  logic             last_grant;
  logic             job_id;
  logic [CNT_W-1:0] cnt;
  logic             grant;
  logic             accept;

  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else begin
      grant = req1_valid;
    end
  end

  assign req0_ready = ARESETN && (state == S_IDLE) && req0_valid && !grant;
  assign req1_ready = ARESETN && (state == S_IDLE) && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;

  assign core_start = (state == S_START);
  assign rsp_valid  = (state == S_RESP);
  assign busy       = (state != S_IDLE);
  assign fsm_state  = state;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      job_id     <= 1'b0;
      cnt        <= '0;
      core_angle <= '0;
      rsp_id     <= 1'b0;
      rsp_cos    <= '0;
      rsp_sin    <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            core_angle <= grant ? req1_angle : req0_angle;
            job_id     <= grant;
            state      <= S_START;
          end
        end
        S_START: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
          end
          if (core_done) begin
            rsp_id  <= job_id;
            rsp_cos <= core_cos;
            rsp_sin <= core_sin;
            rsp_err <= 1'b0;
            state   <= S_RESP;
          end else if (cnt == CNT_FIRE) begin
            rsp_id  <= job_id;
            rsp_cos <= '0;
            rsp_sin <= '0;
            rsp_err <= 1'b1;
            state   <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            last_grant <= rsp_id;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_job_arbiter.sv
// Bench for cordic_job_arbiter: hand table of jobs, back-to-back, reset-abandon and
// randomized jobs checked against a round-robin reference model and expected queue.
module tb_cordic_job_arbiter;

  localparam int DW      = 16;
  localparam int TIMEOUT = 64;
  localparam int RW      = 1 + 2 * DW + 1;

  logic          ACLK;
  logic          ARESETN;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] req0_angle, req1_angle;
  logic          core_start;
  logic [DW-1:0] core_angle;
  logic          core_done;
  logic [DW-1:0] core_cos, core_sin;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [DW-1:0] rsp_cos, rsp_sin;
  logic [1:0]    fsm_state;

  typedef struct {
    logic          v0;
    logic          v1;
    logic [DW-1:0] a0;
    logic [DW-1:0] a1;
    int            lat;
    logic [DW-1:0] cos;
    logic [DW-1:0] sin;
    int            hold;
    logic          exp_id;
    logic [DW-1:0] exp_cos;
    logic [DW-1:0] exp_sin;
    logic          exp_err;
    int            exp_c;
  } job_t;

  logic [RW-1:0] exp_q[$];
  int n_vec;
  int n_err;

  cordic_job_arbiter #(.DATA_W(DW), .TIMEOUT(TIMEOUT)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_angle(req0_angle),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_angle(req1_angle),
    .core_start(core_start), .core_angle(core_angle), .core_done(core_done),
    .core_cos(core_cos), .core_sin(core_sin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_cos(rsp_cos), .rsp_sin(rsp_sin), .rsp_err(rsp_err),
    .busy(busy), .fsm_state(fsm_state)
  );

  // clock / reset
  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got still running expected finished");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic job_t mk(input logic v0, input logic v1, input logic [DW-1:0] a0,
                              input logic [DW-1:0] a1, input int lat, input logic [DW-1:0] cos,
                              input logic [DW-1:0] sin, input int hold, input logic exp_id,
                              input logic [DW-1:0] exp_cos, input logic [DW-1:0] exp_sin,
                              input logic exp_err, input int exp_c);
    job_t j;
    j.v0 = v0; j.v1 = v1; j.a0 = a0; j.a1 = a1; j.lat = lat;
    j.cos = cos; j.sin = sin; j.hold = hold; j.exp_id = exp_id;
    j.exp_cos = exp_cos; j.exp_sin = exp_sin; j.exp_err = exp_err; j.exp_c = exp_c;
    return j;
  endfunction

  // Reference model: round robin on ties, result if the core answers within
  // TIMEOUT-1 cycles of core_start, otherwise an error response TIMEOUT cycles after it.
  function automatic job_t model_job(input logic v0, input logic v1, input logic [DW-1:0] a0,
                                     input logic [DW-1:0] a1, input int lat,
                                     input logic [DW-1:0] cos, input logic [DW-1:0] sin,
                                     input int hold, input logic last);
    job_t j;
    j = mk(v0, v1, a0, a1, lat, cos, sin, hold, 1'b0, '0, '0, 1'b0, 0);
    j.exp_id = (v0 && v1) ? !last : v1;
    if (lat <= TIMEOUT - 1) begin
      j.exp_cos = cos; j.exp_sin = sin; j.exp_err = 1'b0; j.exp_c = lat + 2;
    end else begin
      j.exp_cos = '0; j.exp_sin = '0; j.exp_err = 1'b1; j.exp_c = TIMEOUT + 1;
    end
    return j;
  endfunction

  // driver: one complete job, cycle counter c counts from the accept cycle (c = 0)
  task automatic run_job(input job_t j);
    int c;
    logic [RW-1:0] exp_r;
    logic [RW-1:0] got;
    exp_q.push_back({j.exp_id, j.exp_cos, j.exp_sin, j.exp_err});
    @(negedge ACLK);
    req0_valid = j.v0; req1_valid = j.v1; req0_angle = j.a0; req1_angle = j.a1;
    core_cos = j.cos; core_sin = j.sin; rsp_ready = 1'b0; core_done = 1'b0;
    #1;
    check("ready0", 64'(req0_ready), 64'(!j.exp_id));
    check("ready1", 64'(req1_ready), 64'(j.exp_id));
    @(negedge ACLK);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check("core_start", 64'(core_start), 64'(1));
    check("core_angle", 64'(core_angle), 64'(j.exp_id ? j.a1 : j.a0));
    c = 1;
    do begin
      @(negedge ACLK);
      c++;
      core_done = (c == j.lat + 1);
      #1;
    end while (!rsp_valid && c < 300);
    check("rsp_latency", 64'(c), 64'(j.exp_c));
    exp_r = exp_q.pop_front();
    got = {rsp_id, rsp_cos, rsp_sin, rsp_err};
    check("rsp_fields", 64'(got), 64'(exp_r));
    for (int h = 0; h < j.hold; h++) begin
      @(negedge ACLK);
      core_done = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      got = {rsp_id, rsp_cos, rsp_sin, rsp_err};
      check("rsp_hold_stable", 64'({rsp_valid, got}), 64'({1'b1, exp_r}));
      check("hold_no_accept", 64'({req0_ready, req1_ready, core_start}), 64'(0));
    end
    @(negedge ACLK);
    core_done = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge ACLK);
    rsp_ready = 1'b0;
    #1;
    check("idle_after_rsp", 64'({busy, rsp_valid, fsm_state}), 64'(0));
  endtask

  initial begin
    job_t tbl[$];
    job_t j;
    int acc[$];
    int n_rsp;
    int n_bad;
    logic last_start;
    logic model_last;
    int sel;
    int lat;

    n_vec = 0; n_err = 0;
    ARESETN = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_angle = '0; req1_angle = '0; core_done = 1'b0;
    core_cos = '0; core_sin = '0; rsp_ready = 1'b0;

    // reset state
    repeat (3) @(negedge ACLK);
    req0_valid = 1'b1;
    #1;
    check("ready_during_reset", 64'({req0_ready, req1_ready}), 64'(0));
    @(negedge ACLK);
    ARESETN = 1'b1; req0_valid = 1'b0;
    #1;
    check("reset_ctrl", 64'({busy, rsp_valid, core_start, fsm_state}), 64'(0));
    check("reset_data", 64'({core_angle, rsp_id, rsp_err}), 64'(0));
    check("reset_rsp", 64'({rsp_cos, rsp_sin}), 64'(0));

    // table: alternating ties from reset, then single-cycle and boundary jobs
    for (int i = 0; i < 8; i++) begin
      tbl.push_back(mk(1'b1, 1'b1, 16'(16'h0100 + i), 16'(16'h0200 + i), 3 + i,
                       16'(16'h1000 + 16'h11 * i), 16'(16'h2000 + i), 0, 1'(i % 2),
                       16'(16'h1000 + 16'h11 * i), 16'(16'h2000 + i), 1'b0, 5 + i));
    end
    tbl.push_back(mk(1, 0, 16'h1000, 16'h0000, 16,   16'h2000, 16'h0000, 0,  0, 16'h2000, 16'h0000, 0, 18));
    tbl.push_back(mk(0, 1, 16'h0000, 16'h7fff, 2,    16'h1234, 16'habcd, 10, 1, 16'h1234, 16'habcd, 0, 4));
    tbl.push_back(mk(1, 0, 16'h4000, 16'h0000, 1000, 16'hdead, 16'hbeef, 0,  0, 16'h0000, 16'h0000, 1, 65));
    tbl.push_back(mk(0, 1, 16'h0000, 16'hc000, 5,    16'h0123, 16'h4567, 1,  1, 16'h0123, 16'h4567, 0, 7));
    tbl.push_back(mk(1, 0, 16'h8000, 16'h0000, 63,   16'h5555, 16'haaaa, 0,  0, 16'h5555, 16'haaaa, 0, 65));
    tbl.push_back(mk(0, 1, 16'h0000, 16'hffff, 64,   16'h7777, 16'h8888, 2,  1, 16'h0000, 16'h0000, 1, 65));
    tbl.push_back(mk(1, 1, 16'h0001, 16'h0002, 1,    16'h0f0f, 16'hf0f0, 0,  0, 16'h0f0f, 16'hf0f0, 0, 3));
    foreach (tbl[k]) run_job(tbl[k]);

    // back-to-back jobs from requester 1 with a one-cycle core
    n_rsp = 0; last_start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge ACLK);
      if (c == 0) begin
        req1_valid = 1'b1; req1_angle = 16'h2468; core_cos = 16'h0aaa;
        core_sin = 16'h0555; rsp_ready = 1'b1;
      end
      core_done = last_start;
      #1;
      if (req1_ready) acc.push_back(c);
      if (rsp_valid) begin
        n_rsp++;
        check("b2b_rsp", 64'({rsp_id, rsp_cos, rsp_sin, rsp_err}),
              64'({1'b1, 16'h0aaa, 16'h0555, 1'b0}));
      end
      last_start = core_start;
    end
    @(negedge ACLK);
    req1_valid = 1'b0; core_done = 1'b0; rsp_ready = 1'b0;
    check("b2b_accepts", 64'(acc.size()), 64'(5));
    for (int i = 1; i < acc.size(); i++) check("b2b_gap", 64'(acc[i] - acc[i-1]), 64'(4));
    check("b2b_rsps", 64'(n_rsp), 64'(5));

    // reset while waiting on the core abandons the job silently
    @(negedge ACLK);
    req0_valid = 1'b1; req0_angle = 16'h3333;
    #1;
    check("abandon_accept", 64'(req0_ready), 64'(1));
    @(negedge ACLK);
    req0_valid = 1'b0;
    repeat (3) @(negedge ACLK);
    #1;
    check("abandon_in_wait", 64'({busy, fsm_state}), 64'({1'b1, 2'd2}));
    @(negedge ACLK);
    ARESETN = 1'b0; req0_valid = 1'b1;
    #1;
    check("ready_in_reset", 64'(req0_ready), 64'(0));
    @(negedge ACLK);
    ARESETN = 1'b1; req0_valid = 1'b0; core_done = 1'b1; core_cos = 16'hffff; core_sin = 16'hffff;
    #1;
    check("abandon_outputs", 64'({busy, rsp_valid, core_start, core_angle, rsp_id, rsp_err}), 64'(0));
    n_bad = 0;
    repeat (10) begin
      @(negedge ACLK);
      core_done = 1'b0;
      #1;
      if (rsp_valid || busy || rsp_cos != 0 || rsp_sin != 0) n_bad++;
    end
    check("abandon_no_rsp", 64'(n_bad), 64'(0));
    @(negedge ACLK);
    core_done = 1'b1;
    @(negedge ACLK);
    core_done = 1'b0;
    #1;
    check("stray_done_idle", 64'({busy, rsp_valid, fsm_state, rsp_cos, rsp_sin}), 64'(0));

    // randomized jobs against the reference model (last grant is 1 after reset)
    model_last = 1'b1;
    for (int n = 0; n < 25; n++) begin
      sel = $urandom_range(1, 3);
      lat = ($urandom_range(0, 9) == 0) ? 200 : $urandom_range(1, TIMEOUT);
      j = model_job(sel[0], sel[1], 16'($urandom), 16'($urandom), lat,
                    16'($urandom), 16'($urandom), $urandom_range(0, 3), model_last);
      model_last = j.exp_id;
      run_job(j);
    end

    check("exp_q_empty", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
